// File: rtl/rv32_enc_pkg.sv
// Shared RV32I encoder definitions: opcodes, instruction formats and the buffer entry type.
package rv32_enc_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_UNSUP
  } fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic        err;
  } entry_t;

  function automatic fmt_e decode_fmt(input logic [6:0] opcode);
    fmt_e fmt;
    case (opcode)
      OP_LUI, OP_AUIPC:           fmt = FMT_U;
      OP_JAL:                     fmt = FMT_J;
      OP_JALR, OP_LOAD, OP_IMM:   fmt = FMT_I;
      OP_STORE:                   fmt = FMT_S;
      OP_BRANCH:                  fmt = FMT_B;
      OP_REG:                     fmt = FMT_R;
      default:                    fmt = FMT_UNSUP;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Input-field and output-word handshake bundle of the instruction encoder.
interface inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  modport master (
    output in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_inst, out_err
  );

  modport slave (
    input  in_valid, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_inst, out_err
  );
endinterface

// File: rtl/inst_pack.sv
// Combinational RV32I packer: places the immediate into its format's bit positions
// and flags immediates that cannot be represented exactly.
module inst_pack
  import rv32_enc_pkg::*;
(
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] inst,
  output logic        err
);

  fmt_e fmt;
  logic is_shift;
  logic i_hi_eq;
  logic b_hi_eq;
  logic j_hi_eq;

  assign fmt      = decode_fmt(opcode);
  assign is_shift = (opcode == OP_IMM) && (funct3[1:0] == 2'b01);

  // Upper bits must be pure sign extension of the field's top bit.
  assign i_hi_eq = (&imm[31:11]) | ~(|imm[31:11]);
  assign b_hi_eq = (&imm[31:12]) | ~(|imm[31:12]);
  assign j_hi_eq = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    inst = NOP;
    err  = 1'b0;
    case (fmt)
      FMT_U: begin
        inst = {imm[31:12], rd, opcode};
        err  = |imm[11:0];
      end
      FMT_J: begin
        inst = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err  = imm[0] | ~j_hi_eq;
      end
      FMT_I: begin
        if (is_shift) begin
          inst = {funct7, imm[4:0], rs1, funct3, rd, opcode};
          err  = |imm[31:5];
        end else begin
          inst = {imm[11:0], rs1, funct3, rd, opcode};
          err  = ~i_hi_eq;
        end
      end
      FMT_S: begin
        inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err  = ~i_hi_eq;
      end
      FMT_B: begin
        inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err  = imm[0] | ~b_hi_eq;
      end
      FMT_R: begin
        inst = {funct7, rs2, rs1, funct3, rd, opcode};
        err  = 1'b0;
      end
      default: begin
        inst = NOP;
        err  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// Streaming RV32I instruction encoder: packs fields into a word behind a two-entry
// skid buffer and counts erroneous words handed downstream.
module inst_encoder
  import rv32_enc_pkg::*;
#(
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  inst_encoder_if.slave        bus,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t new_word;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [31:0] pack_inst;
  logic        pack_err;
  logic        accept;
  logic        drain;

  inst_pack u_pack (
    .opcode (bus.in_opcode),
    .rd     (bus.in_rd),
    .rs1    (bus.in_rs1),
    .rs2    (bus.in_rs2),
    .funct3 (bus.in_funct3),
    .funct7 (bus.in_funct7),
    .imm    (bus.in_imm),
    .inst   (pack_inst),
    .err    (pack_err)
  );

  assign new_word = '{valid: 1'b1, inst: pack_inst, err: pack_err};

  // in_ready depends only on the skid register, never on out_ready.
  assign bus.in_ready  = ~s_q.valid;
  assign bus.out_valid = m_q.valid;
  assign bus.out_inst  = m_q.inst;
  assign bus.out_err   = m_q.err;
  assign err_cnt       = err_cnt_q;

  assign accept = bus.in_valid & ~s_q.valid;
  assign drain  = m_q.valid & bus.out_ready;

  always_comb begin
    m_d = m_q;
    s_d = s_q;
    if (drain) begin
      if (s_q.valid) begin
        m_d       = s_q;
        s_d.valid = 1'b0;
        if (accept) s_d = new_word;
      end else if (accept) begin
        m_d = new_word;
      end else begin
        m_d.valid = 1'b0;
      end
    end else if (accept) begin
      if (!m_q.valid) m_d = new_word;
      else            s_d = new_word;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (drain && m_q.err && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q       <= '0;
      s_q       <= '0;
      err_cnt_q <= '0;
    end else begin
      m_q       <= m_d;
      s_q       <= s_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed self-checking bench for inst_encoder: encodings, error flags, backpressure, reset.
module tb_inst_encoder;
  import rv32_enc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [15:0] err_cnt;
  int          n_checks;
  int          n_errors;
  int          exp_errcnt;

  inst_encoder_if bus ();

  inst_encoder #(.ERR_CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
    end
  endtask

  task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [31:0] imm);
    bus.in_opcode = op;
    bus.in_rd     = rd;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_funct3 = f3;
    bus.in_funct7 = f7;
    bus.in_imm    = imm;
  endtask

  // One word through an idle encoder with out_ready=1; checks 1-cycle latency and err_cnt.
  task automatic drive_one(input string tag, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] imm,
                           input logic [31:0] exp_inst, input logic exp_err);
    @(negedge clk);
    bus.out_ready = 1'b1;
    set_fields(op, rd, rs1, rs2, f3, f7, imm);
    bus.in_valid = 1'b1;
    check_eq({tag, ".idle_valid"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check_eq({tag, ".inst"}, bus.out_inst, exp_inst);
    check_eq({tag, ".err"}, 32'(bus.out_err), 32'(exp_err));
    if (exp_err) exp_errcnt++;
    @(negedge clk);
    check_eq({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
    check_eq({tag, ".err_cnt"}, 32'(err_cnt), 32'(exp_errcnt));
  endtask

  logic [31:0] bp_imm  [4];
  logic [31:0] bp_inst [4];
  int          in_idx;
  int          out_idx;
  logic        acc;
  logic        drn;

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    exp_errcnt = 0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_fields('0, '0, '0, '0, '0, '0, '0);
    rst_n = 1'b0;
    #12;
    check_eq("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst.out_inst", bus.out_inst, 32'd0);
    check_eq("rst.out_err", 32'(bus.out_err), 32'd0);
    check_eq("rst.in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst.err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive_one("lui", OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0);
    drive_one("addi_m1", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    drive_one("addi_2048", OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h80000093, 1'b1);
    drive_one("sw", OP_STORE, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'hFFFFFFFC, 32'hFE21AE23, 1'b0);
    drive_one("jal", OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0);
    drive_one("beq_odd", OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00000263, 1'b1);
    drive_one("unsup", 7'b1111111, 5'd7, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h00000013, 1'b1);
    drive_one("srai", OP_IMM, 5'd4, 5'd2, 5'd0, 3'b101, 7'b0100000, 32'd3, 32'h40315213, 1'b0);
    drive_one("add", OP_REG, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF, 32'h002081B3, 1'b0);
    drive_one("auipc_low", OP_AUIPC, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h00000017, 1'b1);

    // Backpressure: 4 lui words, out_ready low for the first 5 sampled cycles.
    for (int i = 0; i < 4; i++) begin
      bp_imm[i]  = 32'h11111000 * (i + 1);
      bp_inst[i] = bp_imm[i] | 32'h37;
    end
    in_idx  = 0;
    out_idx = 0;
    for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      bus.in_valid  = (in_idx < 4);
      if (in_idx < 4) set_fields(OP_LUI, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, bp_imm[in_idx]);
      if (cyc == 1) check_eq("bp.ready_after_1", 32'(bus.in_ready), 32'd1);
      if (cyc == 2) check_eq("bp.ready_after_2", 32'(bus.in_ready), 32'd0);
      if (cyc >= 5) check_eq("bp.no_gap", 32'(bus.out_valid), 32'd1);
      if (bus.out_valid) check_eq("bp.order", bus.out_inst, bp_inst[out_idx]);
      acc = bus.in_valid && bus.in_ready;
      drn = bus.out_valid && bus.out_ready;
      @(posedge clk);
      if (acc) in_idx++;
      if (drn) out_idx++;
    end
    check_eq("bp.all_out", 32'(out_idx), 32'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("bp.empty", 32'(bus.out_valid), 32'd0);

    // Fill both entries with error words, then reset asynchronously.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    set_fields(7'b1111111, '0, '0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("full.in_ready", 32'(bus.in_ready), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst.out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst.in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("arst.err_cnt", 32'(err_cnt), 32'd0);
    exp_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_one("post_rst", OP_LUI, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 32'hABCDE4B7, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
